// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg
//   Shared definitions for the timer interrupt controller:
//   - word addresses of the Avalon-MM register map
//   - the output FSM state encoding
//   - the position of the "any active" flag in the ACTIVE register
package timer_irq_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;
  localparam logic [2:0] ADDR_FORCE   = 3'd6;

  localparam int ACTIVE_VALID_BIT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_e;

endpackage

// File: rtl/timer_irq_prio_enc.sv
// timer_irq_prio_enc
//   Combinational priority encoder. The lowest set request index wins.
//   Ports:
//     req   [NUM_IRQ-1:0]  request vector (pending & enable)
//     valid                any request set
//     idx   [3:0]          lowest set index, 0 when none set
module timer_irq_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [3:0]         idx
);

  // Scan from the top down so the last hit, the lowest index, is kept.
  always_comb begin
    valid = |req;
    idx   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
//   Avalon-MM interrupt controller sitting behind the interval timers.
//   Latches each timer irq line into a pending bit (edge or level
//   sensitive), masks with ENABLE and drives one aggregated CPU irq whose
//   re-assertion rate is limited by a programmable holdoff.
//   Ports:
//     clk, reset_n         clock, asynchronous active-low reset
//     address [2:0]        register word address
//     chipselect, write_n  slave select, active-low write strobe
//     writedata [15:0]     write data
//     readdata [15:0]      registered read data (latency 1)
//     irq_in [NUM_IRQ-1:0] timer irq lines, synchronous to clk
//     irq                  registered aggregated interrupt
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int          NUM_IRQ       = 8,
  parameter logic [15:0] EDGE_RESET    = 16'hFFFF,
  parameter logic [15:0] HOLDOFF_RESET = 16'd0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [15:0]        holdoff_q, holdoff_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_out_q, irq_out_d;
  irq_state_e         state_q, state_d;

  logic               wr_en;
  logic               wr_pending, wr_enable, wr_edge, wr_holdoff, wr_force;
  logic [NUM_IRQ-1:0] wdata_irq;
  logic [NUM_IRQ-1:0] rise, set_vec, clr_vec;
  logic [NUM_IRQ-1:0] active;
  logic               act_valid;
  logic [3:0]         act_idx;
  logic [15:0]        rd_data;

  timer_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req   (active),
    .valid (act_valid),
    .idx   (act_idx)
  );

  assign active = pending_q & enable_q;

  // Write decode and register updates. Set beats clear on the same bit so
  // an event arriving together with a W1C is never lost; a level source
  // that stays high simply re-pends every cycle.
  always_comb begin
    wr_en      = chipselect & ~write_n;
    wr_pending = wr_en && (address == ADDR_PENDING);
    wr_enable  = wr_en && (address == ADDR_ENABLE);
    wr_edge    = wr_en && (address == ADDR_EDGE);
    wr_holdoff = wr_en && (address == ADDR_HOLDOFF);
    wr_force   = wr_en && (address == ADDR_FORCE);
    wdata_irq  = writedata[NUM_IRQ-1:0];

    irq_d   = irq_in;
    rise    = irq_in & ~irq_q;
    set_vec = (edge_q & rise) | (~edge_q & irq_in) |
              (wr_force ? wdata_irq : '0);
    clr_vec = wr_pending ? wdata_irq : '0;

    pending_d = (pending_q & ~clr_vec) | set_vec;
    enable_d  = wr_enable  ? wdata_irq : enable_q;
    edge_d    = wr_edge    ? wdata_irq : edge_q;
    holdoff_d = wr_holdoff ? writedata : holdoff_q;
  end

  // Read mux; readdata only reloads on a read access and holds otherwise.
  always_comb begin
    rd_data = 16'd0;
    case (address)
      ADDR_PENDING: rd_data[NUM_IRQ-1:0] = pending_q;
      ADDR_ENABLE:  rd_data[NUM_IRQ-1:0] = enable_q;
      ADDR_EDGE:    rd_data[NUM_IRQ-1:0] = edge_q;
      ADDR_ACTIVE: begin
        rd_data[ACTIVE_VALID_BIT] = act_valid;
        rd_data[3:0]              = act_idx;
      end
      ADDR_HOLDOFF: rd_data = holdoff_q;
      ADDR_RAW:     rd_data[NUM_IRQ-1:0] = irq_q;
      default:      rd_data = 16'd0;
    endcase
    readdata_d = (chipselect && write_n) ? rd_data : readdata_q;
  end

  // Output FSM. HOLD runs for exactly HOLDOFF cycles (count HOLDOFF-1
  // down to 0) before IDLE looks at the active bits again. The count is
  // captured on entry, so HOLDOFF writes during HOLD do not disturb it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (act_valid) state_d = ASSERT;
      end
      ASSERT: begin
        if (!act_valid) begin
          if (holdoff_q == 16'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = holdoff_q - 16'd1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    irq_out_d = (state_d == ASSERT);
  end

  // All state resets asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_q     <= EDGE_RESET[NUM_IRQ-1:0];
      holdoff_q  <= HOLDOFF_RESET;
      cnt_q      <= 16'd0;
      readdata_q <= 16'd0;
      irq_out_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      irq_q      <= irq_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_q     <= edge_d;
      holdoff_q  <= holdoff_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
      state_q    <= state_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_out_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl
//   Directed bench for timer_irq_ctrl (NUM_IRQ=8, default parameters).
//   Inputs change 1ns after each rising edge; outputs are observed at the
//   same point, i.e. after the edge has settled.
module tb_timer_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;

  int testsRun;
  int testsFailed;

  timer_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [15:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [2:0] addr, output logic [15:0] data);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    step();
    chipselect = 1'b0;
    data       = readdata;
  endtask

  logic [15:0] rd;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset_n     = 1'b0;
    address     = 3'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 16'd0;
    irq_in      = 8'd0;
    step();
    step();
    checkOutput("reset_irq", {15'd0, irq}, 16'h0000);
    checkOutput("reset_readdata", readdata, 16'h0000);
    reset_n = 1'b1;
    step();

    readReg(3'd2, rd); checkOutput("reset_edge", rd, 16'h00FF);
    readReg(3'd1, rd); checkOutput("reset_enable", rd, 16'h0000);
    readReg(3'd4, rd); checkOutput("reset_holdoff", rd, 16'h0000);

    // Edge source on bit 0, pulse held 3 cycles.
    writeReg(3'd1, 16'h0001);
    irq_in = 8'h01;
    step(); checkOutput("edge_irq_e1", {15'd0, irq}, 16'h0000);
    step(); checkOutput("edge_irq_e2", {15'd0, irq}, 16'h0001);
    step();
    irq_in = 8'h00;
    readReg(3'd0, rd); checkOutput("edge_pending", rd, 16'h0001);
    writeReg(3'd0, 16'h0001);
    checkOutput("edge_clr_irq_still", {15'd0, irq}, 16'h0001);
    step(); checkOutput("edge_clr_irq_low", {15'd0, irq}, 16'h0000);

    // Level source on bit 2.
    writeReg(3'd2, 16'h0000);
    writeReg(3'd1, 16'h0004);
    irq_in = 8'h04;
    step();
    step(); checkOutput("level_irq", {15'd0, irq}, 16'h0001);
    writeReg(3'd0, 16'h0004);
    readReg(3'd0, rd); checkOutput("level_repend", rd, 16'h0004);
    checkOutput("level_irq_stays", {15'd0, irq}, 16'h0001);
    irq_in = 8'h00;
    step();
    writeReg(3'd0, 16'h0004);
    readReg(3'd0, rd); checkOutput("level_cleared", rd, 16'h0000);
    checkOutput("level_irq_low", {15'd0, irq}, 16'h0000);

    // Priority encoding through ACTIVE.
    writeReg(3'd2, 16'h00FF);
    writeReg(3'd6, 16'h0028);
    writeReg(3'd1, 16'h00FF);
    readReg(3'd3, rd); checkOutput("active_3", rd, 16'h8003);
    writeReg(3'd0, 16'h0008);
    readReg(3'd3, rd); checkOutput("active_5", rd, 16'h8005);
    writeReg(3'd0, 16'h0020);
    readReg(3'd3, rd); checkOutput("active_none", rd, 16'h0000);
    readReg(3'd6, rd); checkOutput("force_reads0", rd, 16'h0000);
    readReg(3'd7, rd); checkOutput("reserved_reads0", rd, 16'h0000);

    // RAW view and edge capture on two lines with ENABLE off.
    writeReg(3'd1, 16'h0000);
    irq_in = 8'h81;
    step();
    irq_in = 8'h00;
    readReg(3'd0, rd); checkOutput("pending_81", rd, 16'h0081);
    irq_in = 8'h81;
    step();
    readReg(3'd5, rd); checkOutput("raw_81", rd, 16'h0081);
    checkOutput("raw_irq_masked", {15'd0, irq}, 16'h0000);
    irq_in = 8'h00;
    writeReg(3'd0, 16'h00FF);
    readReg(3'd0, rd); checkOutput("pending_cleared", rd, 16'h0000);

    // Holdoff of 10 cycles; a HOLDOFF rewrite mid-hold must not matter.
    writeReg(3'd4, 16'd10);
    writeReg(3'd1, 16'h0001);
    writeReg(3'd6, 16'h0001);
    checkOutput("hold_pre", {15'd0, irq}, 16'h0000);
    step(); checkOutput("hold_assert", {15'd0, irq}, 16'h0001);
    writeReg(3'd0, 16'h0001);
    step(); checkOutput("hold_fall", {15'd0, irq}, 16'h0000);
    writeReg(3'd4, 16'd3);
    checkOutput("hold_f1", {15'd0, irq}, 16'h0000);
    writeReg(3'd6, 16'h0001);
    checkOutput("hold_f2", {15'd0, irq}, 16'h0000);
    for (int i = 3; i <= 10; i++) begin
      step();
      checkOutput($sformatf("hold_f%0d", i), {15'd0, irq}, 16'h0000);
    end
    step(); checkOutput("hold_reassert", {15'd0, irq}, 16'h0001);

    // Dropping ENABLE while asserted leaves via the holdoff path.
    writeReg(3'd1, 16'h0000);
    checkOutput("dis_irq_still", {15'd0, irq}, 16'h0001);
    step(); checkOutput("dis_irq_low", {15'd0, irq}, 16'h0000);
    writeReg(3'd0, 16'h00FF);
    writeReg(3'd4, 16'd0);
    for (int i = 0; i < 4; i++) step();

    // Rising edge and W1C on the same bit in the same cycle: set wins.
    irq_in = 8'h02;
    writeReg(3'd0, 16'h0002);
    irq_in = 8'h00;
    readReg(3'd0, rd); checkOutput("conflict_set_wins", rd, 16'h0002);

    // Reset while asserted.
    writeReg(3'd1, 16'h0002);
    writeReg(3'd2, 16'h000F);
    writeReg(3'd4, 16'd5);
    readReg(3'd0, rd);
    checkOutput("prereset_irq", {15'd0, irq}, 16'h0001);
    checkOutput("prereset_readdata", readdata, 16'h0002);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_irq", {15'd0, irq}, 16'h0000);
    checkOutput("midreset_readdata", readdata, 16'h0000);
    step();
    reset_n = 1'b1;
    step();
    readReg(3'd2, rd); checkOutput("postreset_edge", rd, 16'h00FF);
    readReg(3'd0, rd); checkOutput("postreset_pending", rd, 16'h0000);
    readReg(3'd4, rd); checkOutput("postreset_holdoff", rd, 16'h0000);
    checkOutput("postreset_irq", {15'd0, irq}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Avalon-MM interrupt controller directly downstream of the interval timers.
- Collects up to NUM_IRQ timer irq lines (same clock domain) and latches each into a pending bit, either edge- or level-sensitive.
- Masks the pending bits and drives one aggregated irq to the CPU.
- A programmable holdoff limits the CPU interrupt re-assertion rate; an ACTIVE register returns the highest-priority source index.

Parameters:
- NUM_IRQ, 8, number of irq_in sources; legal range 1..15.
- EDGE_RESET, 16'hFFFF, reset value of the EDGE register; bits at NUM_IRQ and above are ignored.
- HOLDOFF_RESET, 0, reset value of the HOLDOFF register, in clk cycles.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  register word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  16  write data
- readdata  output  16  registered read data
- irq_in  input  NUM_IRQ  timer irq lines, active high, synchronous to clk
- irq  output  1  aggregated interrupt to the CPU, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n. Every flop resets asynchronously.
- Reset values:
  - readdata=0, irq=0, PENDING=0, ENABLE=0.
  - EDGE=EDGE_RESET, HOLDOFF=HOLDOFF_RESET.
  - irq_q=0 and FSM=IDLE.
  - Asserting reset mid-operation returns everything to these values immediately.
- Input sampling: irq_q <= irq_in every cycle. rise = irq_in & ~irq_q.
- Pending set (per bit i):
  - EDGE[i]=1: set_i = rise[i].
  - EDGE[i]=0: set_i = irq_in[i].
  - A FORCE write also sets the bits where writedata[i]=1.
- Pending clear: a write to PENDING clears the bits where writedata[i]=1 (write-1-to-clear).
- Set/clear conflict: if set_i and clear_i occur in the same cycle, set wins.
- A level source that is still high re-pends on the next cycle.
- active = PENDING & ENABLE.
- Register map (word addresses). Reads are latched into readdata 1 cycle after the address is presented (read latency 1). Unused bits read 0.
  - 0 PENDING: R = pending bits; W = write-1-to-clear.
  - 1 ENABLE: R/W, [NUM_IRQ-1:0].
  - 2 EDGE: R/W, [NUM_IRQ-1:0].
  - 3 ACTIVE: R only.
    - [15] = |active.
    - [3:0] = lowest index i with active[i]=1; 0 if none.
    - Writes are ignored.
  - 4 HOLDOFF: R/W, 16-bit unsigned.
  - 5 RAW: R = irq_q.
  - 6 FORCE: W-only; reads return 0.
  - 7 reserved: reads 0, writes ignored.
- Write strobe = chipselect & ~write_n & address match. Writes take effect on the next edge.
- Output FSM (irq is a registered copy of state==ASSERT):
  - IDLE: if |active, go to ASSERT.
  - ASSERT: irq=1. When |active==0:
    - HOLDOFF==0: go to IDLE.
    - Otherwise: load cnt=HOLDOFF-1 and go to HOLD.
  - HOLD: irq=0. Each cycle, if cnt==0 go to IDLE, else cnt<=cnt-1.
    - New pending bits accumulate during HOLD but do not assert irq.
    - Exactly HOLDOFF cycles of irq=0 occur before IDLE is re-evaluated.
  - Writing HOLDOFF during HOLD does not affect the running count.
  - Clearing ENABLE during ASSERT deasserts irq through the normal holdoff path.
- Latency: irq_in rising (edge mode, enabled, IDLE) → pending set at edge+1 → irq=1 at edge+2.

Decomposition:
- Shared package timer_irq_pkg holds:
  - address constants ADDR_PENDING=0 … ADDR_FORCE=6;
  - the FSM state enum {IDLE, ASSERT, HOLD};
  - ACTIVE_VALID_BIT=15.
- One sub-module, timer_irq_prio_enc: combinational lowest-index-first priority encoder, NUM_IRQ→{valid, idx[3:0]}.
- Everything else stays in the top module.

Test Plan:
- Reset: drive reset_n=0 mid-ASSERT → irq=0 and readdata=0 immediately; after release, a read of EDGE returns 16'h00FF (NUM_IRQ=8).
- Edge source: ENABLE=0x0001, pulse irq_in[0] for 3 cycles → PENDING=0x0001 and irq=1 two cycles after the rise. Write PENDING=0x0001 → irq=0 with HOLDOFF=0.
- Level source: EDGE=0, ENABLE=0x0004, hold irq_in[2]=1 and write PENDING=0x0004 → bit re-pends, irq stays 1. Drop irq_in[2], clear again → PENDING=0, irq=0.
- Priority: set pending on bits 5 and 3 via FORCE=0x0028, ENABLE=0xFF → ACTIVE reads 0x8003. Clear bit 3 → ACTIVE reads 0x8005. Clear bit 5 → ACTIVE reads 0x0000.
- Holdoff: HOLDOFF=10, ENABLE=0x01, FORCE=0x01, then clear. Re-FORCE 2 cycles after irq falls → irq stays 0 for exactly 10 cycles after it fell, then asserts 2 cycles later.
- Conflict: in the same cycle irq_in[1] rises (edge mode) and PENDING is written with 0x0002 → PENDING[1]=1 afterwards.
